// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec: operation request with valid/ready,
// and a held result with valid/ready plus a busy indication.
interface alu_exec_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, alu_op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_exec.sv
// Registered RV32-style ALU with valid/ready handshake and iterative shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a barrel shifter.
module alu_exec #(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        rst_n,
  alu_exec_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;

  logic            in_ready;
  logic            accept;
  logic [4:0]      shamt;
  logic            is_shift;
  logic            iter_shift;
  logic            eq, lt_s, lt_u;
  logic [XLEN-1:0] calc;
  logic [XLEN-1:0] shift1;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign shamt    = bus.b[4:0];
  assign is_shift = (bus.alu_op == 4'b1011) || (bus.alu_op == 4'b1100) ||
                    (bus.alu_op == 4'b1101);

`ifdef ALU_FAST_SHIFT_EN
  assign iter_shift = 1'b0;
`else
  assign iter_shift = is_shift && (shamt != 5'd0);
`endif

  assign eq   = (bus.a == bus.b);
  assign lt_s = ($signed(bus.a) < $signed(bus.b));
  assign lt_u = (bus.a < bus.b);

  always_comb begin
    calc = '0;
    case (bus.alu_op)
      4'b0000: calc = XLEN'(eq);
      4'b0001: calc = XLEN'(!eq);
      4'b0010: calc = XLEN'(lt_s);
      4'b0011: calc = XLEN'(lt_u);
      4'b0100: calc = XLEN'(!lt_s);
      4'b0101: calc = XLEN'(!lt_u);
      4'b0110: calc = bus.a + bus.b;
      4'b0111: calc = bus.b;
      4'b1000: calc = bus.a ^ bus.b;
      4'b1001: calc = bus.a | bus.b;
      4'b1010: calc = bus.a & bus.b;
`ifdef ALU_FAST_SHIFT_EN
      4'b1011: calc = bus.a << shamt;
      4'b1100: calc = $signed(bus.a) >>> shamt;
      4'b1101: calc = bus.a >> shamt;
`else
      // Only reached with shamt 0; non-zero amounts go through SHIFT.
      4'b1011, 4'b1100, 4'b1101: calc = bus.a;
`endif
      4'b1110: calc = bus.a - bus.b;
      default: calc = bus.a + bus.b;
    endcase
  end

  always_comb begin
    case (op_q)
      4'b1011: shift1 = {result_q[XLEN-2:0], 1'b0};
      4'b1100: shift1 = {result_q[XLEN-1], result_q[XLEN-1:1]};
      default: shift1 = {1'b0, result_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          op_d = bus.alu_op;
          if (iter_shift) begin
            result_d = bus.a;
            cnt_d    = shamt;
            state_d  = SHIFT;
          end else begin
            result_d = calc;
            state_d  = DONE;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        result_d = shift1;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: driver pushes expected results, a negedge
// monitor pops them on every output handshake.
module tb_alu_exec;

  logic clk;
  logic rst_n;
  logic rand_rdy;
  int   n_checks;
  int   n_fail;
  int   n_pop;
  logic [31:0] exp_q[$];

  alu_exec_if #(.XLEN(32)) bus();

  alu_exec #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    longint signed sa, sb;
    sh = b % 32;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd0:  return (a == b) ? 32'd1 : 32'd0;
      4'd1:  return (a != b) ? 32'd1 : 32'd0;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd4:  return (sa >= sb) ? 32'd1 : 32'd0;
      4'd5:  return (longint'(a) >= longint'(b)) ? 32'd1 : 32'd0;
      4'd6:  return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      4'd7:  return b;
      4'd8:  return a ^ b;
      4'd9:  return a | b;
      4'd10: return a & b;
      4'd11: return 32'((longint'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd12: return 32'(sa / (64'sd1 <<< sh) - ((sa < 0 && (sa % (64'sd1 <<< sh)) != 0) ? 1 : 0));
      4'd13: return 32'(longint'(a) / (64'd1 << sh));
      4'd14: return 32'((64'h1_0000_0000 + longint'(a) - longint'(b)) % 64'h1_0000_0000);
      default: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
    if (!FAST && (op == 4'd11 || op == 4'd12 || op == 4'd13)) return int'(b % 32) + 1;
    return 1;
  endfunction

  // Monitor: one pop per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          chk("result", bus.result, exp_q.pop_front());
        end
        n_pop++;
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] req);
    int n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      exp_q.push_back(req);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  task automatic wait_out(input string name, input int lat_req);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 100) begin
      chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
      lat++;
      @(negedge clk);
    end
    chk({name, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
    chk({name, "_latency"}, lat, lat_req);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          pop0;
    n_checks = 0;
    n_fail   = 0;
    n_pop    = 0;
    rand_rdy = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = '0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    bus.out_ready = 1'b1;
    issue(4'b0110, 32'd5, 32'd7, 32'd12);
    wait_out("add", 1);
    issue(4'b1110, 32'd3, 32'd5, 32'hFFFF_FFFE);
    wait_out("sub", 1);

    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1);
    wait_out("lt", 1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
    wait_out("ltu", 1);
    issue(4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0);
    wait_out("ge", 1);
    issue(4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1);
    wait_out("geu", 1);
    issue(4'b0000, 32'd9, 32'd9, 32'd1);
    wait_out("eq", 1);

    issue(4'b1100, 32'h8000_0000, 32'h24, 32'hF800_0000);
    wait_out("sra", FAST ? 1 : 5);
    issue(4'b1101, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
    wait_out("srl0", 1);
    issue(4'b0111, 32'h1111_1111, 32'h1234_5000, 32'h1234_5000);
    wait_out("lui", 1);
    issue(4'b1011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_out("sll31", FAST ? 1 : 32);
    repeat (2) @(negedge clk);

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    issue(4'b0110, 32'd100, 32'd23, 32'd123);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_result", bus.result, 32'd123);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Back-to-back ADDs: one accept and one result per cycle.
    pop0 = n_pop;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.alu_op = 4'b0110;
      bus.a      = 32'(i);
      bus.b      = 32'd1000;
      @(negedge clk);
      chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i > 0) chk("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
      exp_q.push_back(32'(i) + 32'd1000);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid_last", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    chk("b2b_pops", n_pop - pop0, 32'd8);
    drain();

    // Reset in the middle of a long shift abandons it.
    issue(4'b1011, 32'h0000_0003, 32'd20, 32'h0030_0000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("mid_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
    end

    // Random mix with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 40));
        1:       rb = ra;
        2:       rb = {$urandom_range(0, 7) == 0 ? 27'd0 : 27'($urandom), 5'($urandom)};
        default: rb = $urandom;
      endcase
      issue(op, ra, rb, ref_alu(op, ra, rb));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
